pipeline_hazard_ctrl: RTL and testbench

Sequencing controller for the F/D/E/W pipeline.
- Generates `stall_F`, `flush_F`, `stall_D` and `flush_D` for the FD and DE registers.
- Drives a bubble into the always-capturing EW register while E is stalled.
- Forwards the W-stage result into E operands and holds E operands stable across multi-cycle stalls (memory wait and multi-cycle ALU ops).
- Keeps saturating stall and flush event counters for debug.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/operand_fwd_hold.sv | 42 ++++
 rtl/pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the F/D/E/W pipeline sequencing controller.
// Holds the controller state enum, the no-write write mode and the register address width.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MULTI    = 2'd2
    } state_e;

    localparam logic [1:0] WM_NONE    = 2'b00;
    localparam int         REG_ADDR_W = 3;

endpackage

// File: rtl/operand_fwd_hold.sv
// One E-stage operand path: W-stage forward compare, forward mux and stall hold register.
// Ports: clk/reset, rs_i, rd_w_i, write_mode_w_i, w_data_i, de_data_i, capture_i,
//        use_hold_i in; fwd_o, operand_o out.
module operand_fwd_hold
    import pipe_ctrl_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] rd_w_i,
    input  logic [1:0]            write_mode_w_i,
    input  logic [DW-1:0]         w_data_i,
    input  logic [DW-1:0]         de_data_i,
    input  logic                  capture_i,
    input  logic                  use_hold_i,
    output logic                  fwd_o,
    output logic [DW-1:0]         operand_o
);

    logic [DW-1:0] fwd_val;
    logic [DW-1:0] hold_q;
    logic [DW-1:0] hold_d;

    assign fwd_o   = (write_mode_w_i != WM_NONE) && (rs_i == rd_w_i);
    assign fwd_val = fwd_o ? w_data_i : de_data_i;

    // Snapshot taken on the stall-entry cycle so later W-stage
    // traffic cannot disturb the operand of the stalled instruction.
    assign hold_d    = capture_i ? fwd_val : hold_q;
    assign operand_o = use_hold_i ? hold_q : fwd_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencing, EW bubble, operand forwarding/hold and debug counters for F/D/E/W.
// Ports: clk, reset (async active-low), E/W hazard inputs in; stall/flush/bubble, fwd,
//        operands and saturating stall/flush counters out.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULTI_CYCLES = 4,
    parameter int DW           = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1_E,
    input  logic [REG_ADDR_W-1:0] rs2_E,
    input  logic [DW-1:0]         de_data_1,
    input  logic [DW-1:0]         de_data_2,
    input  logic [REG_ADDR_W-1:0] rd_W,
    input  logic [1:0]            write_mode_W,
    input  logic [DW-1:0]         w_data,
    input  logic                  mem_read_E,
    input  logic                  mem_ready_E,
    input  logic                  multi_start_E,
    input  logic                  branch_taken_E,
    output logic                  stall_F,
    output logic                  stall_D,
    output logic                  flush_F,
    output logic                  flush_D,
    output logic                  bubble_E,
    output logic                  fwd_a,
    output logic                  fwd_b,
    output logic [DW-1:0]         operand_a_E,
    output logic [DW-1:0]         operand_b_E,
    output logic [15:0]           stall_count,
    output logic [15:0]           flush_count
);

    // The entry cycle already counts as a stall cycle, hence the -2.
    localparam logic [3:0] MULTI_INIT = 4'(MULTI_CYCLES - 2);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;
    logic        load_term;
    logic        stall_c;
    logic        flush_c;
    logic        capture;
    logic        use_hold;

    assign load_term = mem_read_E & ~mem_ready_E;

    always_comb begin
        stall_c = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                stall_c = load_term | multi_start_E;
                if (load_term) begin
                    state_d = MEM_WAIT;
                end else if (multi_start_E) begin
                    state_d = MULTI;
                    cnt_d   = MULTI_INIT;
                end
            end
            MEM_WAIT: begin
                stall_c = ~mem_ready_E;
                if (mem_ready_E) begin
                    state_d = RUN;
                end
            end
            MULTI: begin
                stall_c = (cnt_q != 4'd0);
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // A pending stall always beats a taken branch; the branch
    // is honoured in the release cycle instead.
    assign flush_c  = branch_taken_E & ~stall_c;
    assign stall_F  = stall_c;
    assign stall_D  = stall_c;
    assign bubble_E = stall_c;
    assign flush_F  = flush_c;
    assign flush_D  = flush_c;

    assign capture  = (state_q == RUN) & stall_c;
    assign use_hold = (state_q != RUN);

    assign stall_count_d = (stall_c && stall_count_q != 16'hFFFF)
                         ? stall_count_q + 16'd1 : stall_count_q;
    assign flush_count_d = (flush_c && flush_count_q != 16'hFFFF)
                         ? flush_count_q + 16'd1 : flush_count_q;
    assign stall_count   = stall_count_q;
    assign flush_count   = flush_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            cnt_q         <= 4'd0;
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    operand_fwd_hold #(.DW(DW)) u_op_a (
        .clk            (clk),
        .reset          (reset),
        .rs_i           (rs1_E),
        .rd_w_i         (rd_W),
        .write_mode_w_i (write_mode_W),
        .w_data_i       (w_data),
        .de_data_i      (de_data_1),
        .capture_i      (capture),
        .use_hold_i     (use_hold),
        .fwd_o          (fwd_a),
        .operand_o      (operand_a_E)
    );

    operand_fwd_hold #(.DW(DW)) u_op_b (
        .clk            (clk),
        .reset          (reset),
        .rs_i           (rs2_E),
        .rd_w_i         (rd_W),
        .write_mode_w_i (write_mode_W),
        .w_data_i       (w_data),
        .de_data_i      (de_data_2),
        .capture_i      (capture),
        .use_hold_i     (use_hold),
        .fwd_o          (fwd_b),
        .operand_o      (operand_b_E)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (MULTI_CYCLES=4 and =2 instances).
// Stimulus queues hand-computed expectations; a monitor compares them on the falling edge.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  rs1_E, rs2_E, rd_W;
    logic [15:0] de_data_1, de_data_2, w_data;
    logic [1:0]  write_mode_W;
    logic        mem_read_E, mem_ready_E, multi_start_E, branch_taken_E;
    logic        m2_start;

    logic        stall_F, stall_D, flush_F, flush_D, bubble_E, fwd_a, fwd_b;
    logic [15:0] operand_a_E, operand_b_E, stall_count, flush_count;

    logic        s2_stall_F, s2_stall_D, s2_flush_F, s2_flush_D, s2_bubble;
    logic        s2_fwd_a, s2_fwd_b;
    logic [15:0] s2_op_a, s2_op_b, s2_scnt, s2_fcnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MULTI_CYCLES(4), .DW(16)) dut4 (
        .clk(clk), .reset(reset),
        .rs1_E(rs1_E), .rs2_E(rs2_E),
        .de_data_1(de_data_1), .de_data_2(de_data_2),
        .rd_W(rd_W), .write_mode_W(write_mode_W), .w_data(w_data),
        .mem_read_E(mem_read_E), .mem_ready_E(mem_ready_E),
        .multi_start_E(multi_start_E), .branch_taken_E(branch_taken_E),
        .stall_F(stall_F), .stall_D(stall_D),
        .flush_F(flush_F), .flush_D(flush_D), .bubble_E(bubble_E),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .operand_a_E(operand_a_E), .operand_b_E(operand_b_E),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_hazard_ctrl #(.MULTI_CYCLES(2), .DW(16)) dut2 (
        .clk(clk), .reset(reset),
        .rs1_E(rs1_E), .rs2_E(rs2_E),
        .de_data_1(de_data_1), .de_data_2(de_data_2),
        .rd_W(rd_W), .write_mode_W(write_mode_W), .w_data(w_data),
        .mem_read_E(1'b0), .mem_ready_E(1'b0),
        .multi_start_E(m2_start), .branch_taken_E(1'b0),
        .stall_F(s2_stall_F), .stall_D(s2_stall_D),
        .flush_F(s2_flush_F), .flush_D(s2_flush_D), .bubble_E(s2_bubble),
        .fwd_a(s2_fwd_a), .fwd_b(s2_fwd_b),
        .operand_a_E(s2_op_a), .operand_b_E(s2_op_b),
        .stall_count(s2_scnt), .flush_count(s2_fcnt)
    );

    typedef enum int {
        S_STALLF, S_STALLD, S_FLUSHF, S_FLUSHD, S_BUB, S_FWDA, S_FWDB,
        S_OPA, S_OPB, S_SCNT, S_FCNT, S_STATE, S_STALL2, S_SCNT2
    } sig_e;

    typedef struct {
        string       name;
        sig_e        sig;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   done = 1'b0;

    task automatic expect_v(input string name, input sig_e sig, input logic [15:0] val);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic expect_stall(input string name, input logic v);
        expect_v({name, "_stallF"}, S_STALLF, {15'd0, v});
        expect_v({name, "_stallD"}, S_STALLD, {15'd0, v});
        expect_v({name, "_bubble"}, S_BUB, {15'd0, v});
    endtask

    function automatic logic [15:0] actual(input sig_e s);
        case (s)
            S_STALLF: return {15'd0, stall_F};
            S_STALLD: return {15'd0, stall_D};
            S_FLUSHF: return {15'd0, flush_F};
            S_FLUSHD: return {15'd0, flush_D};
            S_BUB:    return {15'd0, bubble_E};
            S_FWDA:   return {15'd0, fwd_a};
            S_FWDB:   return {15'd0, fwd_b};
            S_OPA:    return operand_a_E;
            S_OPB:    return operand_b_E;
            S_SCNT:   return stall_count;
            S_FCNT:   return flush_count;
            S_STATE:  return {14'd0, dut4.state_q};
            S_STALL2: return {15'd0, s2_stall_F};
            S_SCNT2:  return s2_scnt;
            default:  return 16'hDEAD;
        endcase
    endfunction

    // Monitor: consumes every expectation queued during the preceding half cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [15:0] a;
            e = sb.pop_front();
            a = actual(e.sig);
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, a, e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_mode_W   = 2'b00;
        mem_read_E     = 1'b0;
        mem_ready_E    = 1'b0;
        multi_start_E  = 1'b0;
        branch_taken_E = 1'b0;
        m2_start       = 1'b0;
    endtask

    localparam logic [15:0] ST_RUN   = 16'd0;
    localparam logic [15:0] ST_MEMW  = 16'd1;
    localparam logic [15:0] ST_MULTI = 16'd2;

    initial begin
        reset = 1'b0;
        rs1_E = 3'd0; rs2_E = 3'd0; rd_W = 3'd0;
        de_data_1 = 16'h0; de_data_2 = 16'h0; w_data = 16'h0;
        idle();
        #1;
        expect_v("rst_scnt", S_SCNT, 16'd0);
        expect_v("rst_fcnt", S_FCNT, 16'd0);
        expect_v("rst_state", S_STATE, ST_RUN);
        expect_stall("rst", 1'b0);
        step();
        step();
        reset = 1'b1;

        // Forwarding
        step();
        rd_W = 3'd3; write_mode_W = 2'b01; rs1_E = 3'd3;
        w_data = 16'h1234; de_data_1 = 16'h0000;
        rs2_E = 3'd5; de_data_2 = 16'h0055;
        expect_v("fwd_a_on", S_FWDA, 16'd1);
        expect_v("opa_fwd", S_OPA, 16'h1234);
        expect_v("fwd_b_off", S_FWDB, 16'd0);
        expect_v("opb_de", S_OPB, 16'h0055);
        step();
        write_mode_W = 2'b00;
        expect_v("fwd_a_nowr", S_FWDA, 16'd0);
        expect_v("opa_nowr", S_OPA, 16'h0000);

        // Branch in RUN
        step();
        branch_taken_E = 1'b1;
        expect_v("br_flushF", S_FLUSHF, 16'd1);
        expect_v("br_flushD", S_FLUSHD, 16'd1);
        expect_stall("br", 1'b0);
        expect_v("br_fcnt0", S_FCNT, 16'd0);
        step();
        branch_taken_E = 1'b0;
        expect_v("br_fcnt1", S_FCNT, 16'd1);
        expect_v("br_off", S_FLUSHF, 16'd0);

        // Memory wait, 3 not-ready cycles
        step();
        write_mode_W = 2'b01; rd_W = 3'd3; rs1_E = 3'd3;
        w_data = 16'h1234; de_data_1 = 16'h0000;
        mem_read_E = 1'b1; mem_ready_E = 1'b0;
        expect_stall("mw0", 1'b1);
        expect_v("mw0_fwda", S_FWDA, 16'd1);
        expect_v("mw0_opa", S_OPA, 16'h1234);
        step();
        w_data = 16'hBEEF;
        expect_stall("mw1", 1'b1);
        expect_v("mw1_state", S_STATE, ST_MEMW);
        expect_v("mw1_opa", S_OPA, 16'h1234);
        step();
        expect_stall("mw2", 1'b1);
        expect_v("mw2_opa", S_OPA, 16'h1234);
        step();
        mem_ready_E = 1'b1;
        expect_stall("mw_rdy", 1'b0);
        expect_v("mw_rdy_opa", S_OPA, 16'h1234);
        expect_v("mw_scnt", S_SCNT, 16'd3);
        step();
        idle();
        write_mode_W = 2'b01;
        expect_v("mw_back", S_STATE, ST_RUN);
        expect_v("mw_back_opa", S_OPA, 16'hBEEF);
        write_mode_W = 2'b01;

        // Multi-cycle, MULTI_CYCLES=4 and MULTI_CYCLES=2
        step();
        idle();
        multi_start_E = 1'b1;
        m2_start = 1'b1;
        expect_stall("mc0", 1'b1);
        expect_v("m2_0", S_STALL2, 16'd1);
        step();
        multi_start_E = 1'b0;
        m2_start = 1'b0;
        expect_stall("mc1", 1'b1);
        expect_v("mc1_state", S_STATE, ST_MULTI);
        expect_v("m2_1", S_STALL2, 16'd0);
        step();
        expect_stall("mc2", 1'b1);
        expect_v("m2_2", S_STALL2, 16'd0);
        step();
        expect_stall("mc3", 1'b0);
        expect_v("m2_scnt", S_SCNT2, 16'd1);
        step();
        expect_v("mc_state", S_STATE, ST_RUN);
        expect_stall("mc4", 1'b0);
        expect_v("mc_scnt", S_SCNT, 16'd6);

        // Branch vs. load stall entry
        step();
        branch_taken_E = 1'b1; mem_read_E = 1'b1; mem_ready_E = 1'b0;
        expect_v("pr0_flush", S_FLUSHF, 16'd0);
        expect_stall("pr0", 1'b1);
        step();
        expect_v("pr1_flush", S_FLUSHD, 16'd0);
        step();
        mem_ready_E = 1'b1;
        expect_v("pr_rel_flushF", S_FLUSHF, 16'd1);
        expect_v("pr_rel_flushD", S_FLUSHD, 16'd1);
        expect_stall("pr_rel", 1'b0);
        step();
        idle();
        expect_v("pr_fcnt", S_FCNT, 16'd2);
        expect_v("pr_scnt", S_SCNT, 16'd8);
        expect_v("pr_off", S_FLUSHF, 16'd0);

        // Reset in the second stall cycle of a multi-cycle op
        step();
        multi_start_E = 1'b1;
        expect_stall("rm0", 1'b1);
        step();
        multi_start_E = 1'b0;
        reset = 1'b0;
        expect_stall("rm_rst", 1'b0);
        expect_v("rm_state", S_STATE, ST_RUN);
        expect_v("rm_scnt", S_SCNT, 16'd0);
        expect_v("rm_fcnt", S_FCNT, 16'd0);
        step();
        reset = 1'b1;
        step();
        multi_start_E = 1'b1;
        expect_stall("ra0", 1'b1);
        step();
        multi_start_E = 1'b0;
        expect_stall("ra1", 1'b1);
        step();
        expect_stall("ra2", 1'b1);
        step();
        expect_stall("ra3", 1'b0);
        expect_v("ra_scnt", S_SCNT, 16'd3);

        // Saturation
        step();
        force dut4.stall_count_q = 16'hFFFF;
        force dut4.flush_count_q = 16'hFFFF;
        #1;
        release dut4.stall_count_q;
        release dut4.flush_count_q;
        step();
        multi_start_E = 1'b1;
        expect_stall("sat0", 1'b1);
        step();
        multi_start_E = 1'b0;
        step();
        step();
        expect_v("sat_scnt", S_SCNT, 16'hFFFF);
        step();
        branch_taken_E = 1'b1;
        expect_v("sat_flush", S_FLUSHF, 16'd1);
        step();
        branch_taken_E = 1'b0;
        expect_v("sat_fcnt", S_FCNT, 16'hFFFF);
        expect_v("sat_scnt2", S_SCNT, 16'hFFFF);

        step();
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule
